// File: rtl/gcd_pkg.sv
// GCD controller shared definitions: ALU function codes, FSM state codes, iteration counter helpers.
// Latency: n/a (package).
// Backpressure: n/a (package).
package gcd_pkg;

    // ALU function select
    typedef logic [1:0] alu_fn_t;

    localparam alu_fn_t FN_A_MINUS_B = 2'b00;
    localparam alu_fn_t FN_B_MINUS_A = 2'b01;
    localparam alu_fn_t FN_PASS_A    = 2'b10;
    localparam alu_fn_t FN_PASS_B    = 2'b11;

    // ALU status flags derived from the ALU output word
    typedef struct packed {
        logic z;    // output is all zeros
        logic n;    // output MSB set
    } alu_flags_t;

    // FSM state codes; the controller zero-extends these into its W-bit state register
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CHKA  = 3'd1;
    localparam logic [2:0] ST_CHKB  = 3'd2;
    localparam logic [2:0] ST_CMP   = 3'd3;
    localparam logic [2:0] ST_SUBBA = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;

    // Iteration counter (only used when GCD_ITER_COUNT_EN is defined)
    localparam int         ITER_W   = 8;
    localparam logic [7:0] ITER_MAX = 8'hFF;

    // Saturating increment: stick at ITER_MAX instead of wrapping
    function automatic logic [7:0] iter_next(input logic [7:0] cur);
        return (cur == ITER_MAX) ? cur : cur + 8'd1;
    endfunction

endpackage

// File: rtl/gcd_ctrl_alu.sv
// Two-operand ALU for the GCD datapath: A-B, B-A, pass A, pass B, with zero and sign flags.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows inputs continuously.
// Ports: a, b (W-bit operands), fn (function select), c (W-bit result), flags (z = c zero, n = c MSB).
module alu
    import gcd_pkg::*;
#(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  alu_fn_t      fn,
    output logic [W-1:0] c,
    output alu_flags_t   flags
);

    logic [W-1:0] minuend;
    logic [W-1:0] subtrahend;
    logic [W-1:0] diff;

    // Both subtract directions share one subtractor by swapping operands
    always_comb begin
        if (fn == FN_B_MINUS_A) begin
            minuend    = b;
            subtrahend = a;
        end else begin
            minuend    = a;
            subtrahend = b;
        end
    end

    assign diff = minuend - subtrahend;

    always_comb begin
        c = diff;
        case (fn)
            FN_PASS_A: c = a;
            FN_PASS_B: c = b;
            default:   c = diff;
        endcase
    end

    assign flags.z = (c == '0);
    assign flags.n = c[W-1];

endmodule

// File: rtl/gcd_ctrl.sv
// GCD controller: repeated-subtraction GCD of one operand pair at a time, optional iteration count (macro GCD_ITER_COUNT_EN adds port iter).
// Latency: accept -> out_valid is 1 cycle for MSB-set operands, otherwise 2 (zero operand) up to 3 + CMP/SUBBA cycles.
// Backpressure: in_ready only in IDLE; result/err held in DONE until out_ready, same-cycle handoff when out_ready already high.
// Ports: clk, rst_n (async active-low); in_valid/in_ready/a_in/b_in operand handshake;
//        out_valid/out_ready/result/err result handshake; iter (8-bit, only with GCD_ITER_COUNT_EN).
module gcd_ctrl
    import gcd_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a_in,
    input  logic [W-1:0] b_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] result,
    output logic         err
`ifdef GCD_ITER_COUNT_EN
    ,
    output logic [7:0]   iter
`endif
);

    // State register is W bits wide; codes are zero-extended from the package
    localparam logic [W-1:0] S_IDLE  = W'(ST_IDLE);
    localparam logic [W-1:0] S_CHKA  = W'(ST_CHKA);
    localparam logic [W-1:0] S_CHKB  = W'(ST_CHKB);
    localparam logic [W-1:0] S_CMP   = W'(ST_CMP);
    localparam logic [W-1:0] S_SUBBA = W'(ST_SUBBA);
    localparam logic [W-1:0] S_DONE  = W'(ST_DONE);

    logic [W-1:0] state;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    alu_fn_t      alu_fn;
    logic [W-1:0] alu_c;
    alu_flags_t   alu_flags;
    logic         accept;
    logic         op_bad;

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign accept    = in_valid & in_ready;
    // Operands are treated as W-1 bit magnitudes; a set MSB would break the N flag as an A<B test
    assign op_bad    = a_in[W-1] | b_in[W-1];

    alu #(
        .W (W)
    ) u_alu (
        .a     (ra),
        .b     (rb),
        .fn    (alu_fn),
        .c     (alu_c),
        .flags (alu_flags)
    );

    always_comb begin
        alu_fn = FN_PASS_A;
        case (state)
            S_CHKA:  alu_fn = FN_PASS_A;
            S_CHKB:  alu_fn = FN_PASS_B;
            S_CMP:   alu_fn = FN_A_MINUS_B;
            S_SUBBA: alu_fn = FN_B_MINUS_A;
            default: alu_fn = FN_PASS_A;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            ra     <= '0;
            rb     <= '0;
            result <= '0;
            err    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        ra  <= a_in;
                        rb  <= b_in;
                        err <= 1'b0;
                        if (op_bad) begin
                            err    <= 1'b1;
                            result <= '0;
                            state  <= S_DONE;
                        end else begin
                            state  <= S_CHKA;
                        end
                    end
                end
                // A zero: gcd(0, b) = b
                S_CHKA: begin
                    if (alu_flags.z) begin
                        result <= rb;
                        state  <= S_DONE;
                    end else begin
                        state  <= S_CHKB;
                    end
                end
                // B zero: gcd(a, 0) = a
                S_CHKB: begin
                    if (alu_flags.z) begin
                        result <= ra;
                        state  <= S_DONE;
                    end else begin
                        state  <= S_CMP;
                    end
                end
                // A-B: equal ends the loop, negative means B is larger, else shrink A
                S_CMP: begin
                    if (alu_flags.z) begin
                        result <= ra;
                        state  <= S_DONE;
                    end else if (alu_flags.n) begin
                        state  <= S_SUBBA;
                    end else begin
                        ra     <= alu_c;
                    end
                end
                S_SUBBA: begin
                    rb    <= alu_c;
                    state <= S_CMP;
                end
                S_DONE: begin
                    if (out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef GCD_ITER_COUNT_EN
    // Counts CMP and SUBBA cycles of the current pair; frozen in DONE, so valid with out_valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iter <= '0;
        end else if (accept) begin
            iter <= '0;
        end else if ((state == S_CMP) || (state == S_SUBBA)) begin
            iter <= iter_next(iter);
        end
    end
`endif

endmodule

// File: tb/tb_gcd_ctrl.sv
// Testbench for gcd_ctrl: vector table plus directed stall/reset/back-to-back sequences, scoreboard-checked.
// Latency: n/a (testbench).
// Backpressure: exercises out_ready low stalls and out_ready tied high.
module tb_gcd_ctrl;

    localparam int W     = 16;
    localparam int LIMIT = 40000;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         err;
`ifdef GCD_ITER_COUNT_EN
    logic [7:0]   iter;
`endif

    gcd_ctrl #(
        .W (W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_in      (a_in),
        .b_in      (b_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .err       (err)
`ifdef GCD_ITER_COUNT_EN
        ,
        .iter      (iter)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] r;
        logic         e;
        int           it;
    } vec_t;

    typedef struct {
        logic [W-1:0] r;
        logic         e;
        int           it;
        bit           chk_it;
    } exp_t;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [W-1:0] r, input logic e, input int it, input bit chk);
        exp_t x;
        x.r = r; x.e = e; x.it = it; x.chk_it = chk;
        return x;
    endfunction

    // Euclid by remainder, independent of the subtraction loop in the design
    function automatic logic [W-1:0] gcd_ref(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] x, y, t;
        x = a; y = b;
        while (y != 0) begin
            t = x % y; x = y; y = t;
        end
        return x;
    endfunction

    // Result monitor: every completed transfer must match the oldest expectation
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_output: got result %0h err %0b, expected no output", result, err);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result", 32'(result), 32'(e.r));
                check("err", 32'(err), 32'(e.e));
`ifdef GCD_ITER_COUNT_EN
                if (e.chk_it) check("iter", 32'(iter), 32'(e.it));
`endif
            end
        end
    end

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input exp_t e, input bit push);
        int  cyc;
        bit  done;
        cyc  = 0;
        done = 0;
        @(posedge clk); #1;
        a_in = a; b_in = b; in_valid = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                done = 1;
                if (push) sb.push_back(e);
            end else if (++cyc > LIMIT) begin
                check("send_timeout", 32'(in_ready), 32'd1);
                done = 1;
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int cyc;
        cyc = 0;
        while (sb.size() != 0 && cyc < LIMIT) begin
            @(negedge clk);
            cyc++;
        end
        check("drain_pending", 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    vec_t vecs[14];

    initial begin
        bit bad;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a_in      = '0;
        b_in      = '0;

        vecs[0]  = '{16'd48,   16'd18,   16'd6,    1'b0, 6};
        vecs[1]  = '{16'd0,    16'd35,   16'd35,   1'b0, 0};
        vecs[2]  = '{16'd35,   16'd0,    16'd35,   1'b0, 0};
        vecs[3]  = '{16'd0,    16'd0,    16'd0,    1'b0, 0};
        vecs[4]  = '{16'h8001, 16'd3,    16'd0,    1'b1, 0};
        vecs[5]  = '{16'd5,    16'hFFFF, 16'd0,    1'b1, 0};
        vecs[6]  = '{16'd21,   16'd14,   16'd7,    1'b0, 4};
        vecs[7]  = '{16'd7,    16'd7,    16'd7,    1'b0, 1};
        vecs[8]  = '{16'd12,   16'd18,   16'd6,    1'b0, 4};
        vecs[9]  = '{16'd17,   16'd5,    16'd1,    1'b0, 9};
        vecs[10] = '{16'd1,    16'd1,    16'd1,    1'b0, 1};
        vecs[11] = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b0, 1};
        vecs[12] = '{16'd1000, 16'd1,    16'd1,    1'b0, 255};
        vecs[13] = '{16'h7FFF, 16'd1,    16'd1,    1'b0, 255};

        // Reset state
        #3;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_err", 32'(err), 32'd0);
`ifdef GCD_ITER_COUNT_EN
        check("rst_iter", 32'(iter), 32'd0);
`endif
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Vector table, one pair at a time
        for (int i = 0; i < 14; i++) begin
            send(vecs[i].a, vecs[i].b, mk(vecs[i].r, vecs[i].e, vecs[i].it, 1'b1), 1'b1);
            drain();
        end

        // MSB-set operand: DONE the cycle after accept, IDLE the cycle after that
        send(16'h8001, 16'd3, mk(16'd0, 1'b1, 0, 1'b1), 1'b1);
        @(negedge clk);
        check("err_fast_valid", 32'(out_valid), 32'd1);
        @(negedge clk);
        check("err_idle_next", 32'(in_ready), 32'd1);
        check("err_valid_drop", 32'(out_valid), 32'd0);
        drain();

        // Random small operands against the reference model
        for (int i = 0; i < 8; i++) begin
            logic [W-1:0] ra, rb;
            ra = W'($urandom_range(0, 255));
            rb = W'($urandom_range(0, 255));
            send(ra, rb, mk(gcd_ref(ra, rb), 1'b0, 0, 1'b0), 1'b1);
            drain();
        end

        // DONE stall: result held, in_ready low, in_valid pulses ignored
        out_ready = 1'b0;
        send(16'd48, 16'd18, mk(16'd6, 1'b0, 6, 1'b1), 1'b1);
        begin
            int cyc;
            cyc = 0;
            while (!out_valid && cyc < 1000) begin
                @(negedge clk);
                cyc++;
            end
        end
        check("stall_reach_done", 32'(out_valid), 32'd1);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 2) begin
                a_in = 16'd9; b_in = 16'd3; in_valid = 1'b1;
            end
            if (i == 5) in_valid = 1'b0;
            if (!out_valid || in_ready || result !== 16'd6) bad = 1;
        end
        check("stall_hold", 32'(bad), 32'd0);
        out_ready = 1'b1;
        drain();
        repeat (20) @(negedge clk);

        // Reset during CMP abandons the pair silently
        send(16'd1000, 16'd1, mk(16'd0, 1'b0, 0, 1'b0), 1'b0);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_result", 32'(result), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid || !in_ready) bad = 1;
        end
        check("midrst_quiet", 32'(bad), 32'd0);
        send(16'd21, 16'd14, mk(16'd7, 1'b0, 4, 1'b1), 1'b1);
        drain();

        // Back-to-back pairs with out_ready tied high
        send(16'd48,   16'd18, mk(16'd6,  1'b0, 6, 1'b1), 1'b1);
        send(16'd21,   16'd14, mk(16'd7,  1'b0, 4, 1'b1), 1'b1);
        send(16'h8001, 16'd3,  mk(16'd0,  1'b1, 0, 1'b1), 1'b1);
        send(16'd0,    16'd35, mk(16'd35, 1'b0, 0, 1'b1), 1'b1);
        send(16'd17,   16'd5,  mk(16'd1,  1'b0, 9, 1'b1), 1'b1);
        drain();
        repeat (10) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gcd_ctrl.md
GCD_CTRL -- requirements
Module: gcd_ctrl

Interface
REQ-001 SHALL have parameter W, default 16, meaning operand/result width in bits.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port in_valid  input  1  operand pair offered.
REQ-005 SHALL have port in_ready  output  1  controller accepts an operand pair.
REQ-006 SHALL have port a_in  input  W  first operand.
REQ-007 SHALL have port b_in  input  W  second operand.
REQ-008 SHALL have port out_valid  output  1  result available.
REQ-009 SHALL have port out_ready  input  1  consumer takes the result.
REQ-010 SHALL have port result  output  W  GCD of the accepted pair.
REQ-011 SHALL have port err  output  1  accepted pair had an operand with MSB set.

Function
REQ-012 SHALL compute GCD by repeated subtraction, with all arithmetic and flags taken from one ALU instance (fn 00 A-B, 01 B-A, 10 pass A, 11 pass B; Z = result zero, N = result MSB).
REQ-013 SHALL use states IDLE, CHKA, CHKB, CMP, SUBBA, DONE; the state register and the operand registers ra and rb are W bits wide.
REQ-014 SHALL, in IDLE, drive in_ready=1; on in_valid&in_ready, load ra=a_in and rb=b_in, then go to CHKA; in_ready=0 in every other state.
REQ-015 SHALL, on accept, check a_in[W-1] and b_in[W-1]; if either is 1, set err=1 and result=0, and go to DONE, skipping the computation.
REQ-016 SHALL, in CHKA, drive fn=10; if Z, set result=rb and go to DONE; otherwise go to CHKB.
REQ-017 SHALL, in CHKB, drive fn=11; if Z, set result=ra and go to DONE; otherwise go to CMP.
REQ-018 SHALL, in CMP, drive fn=00, then:
  - if Z, set result=ra and go to DONE;
  - else if N, go to SUBBA;
  - else set ra=C and stay in CMP.
REQ-019 SHALL, in SUBBA, drive fn=01, set rb=C, and return to CMP.
REQ-020 SHALL, in DONE, drive out_valid=1 and hold result and err stable until out_valid&out_ready, then go to IDLE.
REQ-021 SHALL clear err on the next accept.
REQ-022 SHALL ignore in_valid outside IDLE; an offered pair is not lost, because in_ready=0 outside IDLE.
REQ-023 SHALL, when out_ready is already high on DONE entry, complete the transfer in that single cycle, so IDLE follows in the next cycle.
REQ-024 SHALL treat operands as non-negative W-1-bit values, so that N is a valid A<B indicator.
REQ-025 SHALL never loop forever: zero operands exit at CHKA or CHKB, and nonzero operands strictly decrease.

Reset
REQ-026 SHALL, while rst_n=0, force state=IDLE and ra=rb=result=0, and clear err, out_valid and the iteration counter; in_ready=1 follows from IDLE.
REQ-027 SHALL, on reset asserted mid-computation, abandon the computation without producing out_valid; the first pair accepted after reset computes normally.

Configuration
REQ-028 SHALL, with macro GCD_ITER_COUNT_EN defined, add output port iter (output, 8 bits):
  - iter counts CMP and SUBBA cycles for the current pair;
  - iter is cleared on accept and saturates at 255;
  - iter is valid while out_valid=1.
REQ-029 SHALL, without GCD_ITER_COUNT_EN, have neither the port iter nor the counter, with all other behaviour identical.

Structure
REQ-030 SHALL place the ALU fn encodings (FN_A_MINUS_B, FN_B_MINUS_A, FN_PASS_A, FN_PASS_B) and the state encoding in a shared package gcd_pkg.
REQ-031 SHALL instantiate the existing alu module as its single sub-module, with parameter W passed through; no other subtractor is permitted.

Verification
REQ-032 SHALL cover: a=48, b=18 -> result=6, err=0; with GCD_ITER_COUNT_EN, iter=6 (5 CMP + 1 SUBBA).
REQ-033 SHALL cover: a=0, b=35 -> result=35 via CHKA; a=35, b=0 -> result=35 via CHKB; a=0, b=0 -> result=0.
REQ-034 SHALL cover: a=16'h8001, b=3 -> out_valid with result=0, err=1, and no CMP state entered.
REQ-035 SHALL cover: out_ready held low 10 cycles in DONE -> result stable and in_ready=0 throughout; in_valid pulsed meanwhile -> not accepted.
REQ-036 SHALL cover: rst_n pulsed low during CMP for a=1000, b=1 -> out_valid stays 0, in_ready=1 after release; then a=21, b=14 -> result=7.
REQ-037 SHALL cover: back-to-back pairs with out_ready tied high -> one result per pair, in order, and iter reset per pair.
